// File: rtl/isa_io_target_if.sv
// ISA I/O target bus bundle: host-side strobes, DMA handshake and
// the local FIFO drain port.
interface isa_io_target_if;
    logic [15:0] address;
    logic        aen;
    logic        ior;
    logic        iow;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        dack;
    logic        drq;
    logic        irq;
    logic [7:0]  local_rd_data;
    logic        local_rd_valid;
    logic        local_rd_ready;
    logic        local_irq_req;

    modport slave (
        input  address, aen, ior, iow, data_in, dack,
        input  local_rd_ready, local_irq_req,
        output data_out, data_oe, drq, irq,
        output local_rd_data, local_rd_valid
    );

    modport master (
        output address, aen, ior, iow, data_in, dack,
        output local_rd_ready, local_irq_req,
        input  data_out, data_oe, drq, irq,
        input  local_rd_data, local_rd_valid
    );
endinterface

// File: rtl/isa_io_target.sv
// ISA I/O-slave responder: 16-byte register window, PIO/DMA byte
// intake into a local FIFO, IRQ on terminal count or local request.
module isa_io_target #(
    parameter logic [15:0] BASE_ADDR   = 16'h0220,
    parameter int          FIFO_DEPTH  = 16,
    parameter int          SYNC_STAGES = 2
) (
    input logic            clk,
    input logic            reset_n,
    isa_io_target_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = 20;
    localparam logic [SW-1:0] SYNC_RST = {16'h0000, 4'b1111};

    typedef enum logic [1:0] {IDLE, IO_RD, IO_WR, DMA_WR} cyc_t;

    logic [SW-1:0]          sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] sync_vld;
    logic [15:0]            addr_s;
    logic                   aen_s, ior_s, iow_s, dack_s, sync_ok;
    logic                   ior_d, iow_d, ior_arm, iow_arm;
    logic                   ior_fall, ior_rise, iow_fall, iow_rise;
    logic                   sel, dma_sel;

    cyc_t state, state_n;
    logic rd_start, rd_end, wr_done, dma_done, cyc_dma;

    logic [3:0]  off_q;
    logic [1:0]  ctrl;
    logic [7:0]  cnt_lo, cnt_hi, scratch;
    logic        irq_pending, overflow, dma_active;
    logic [16:0] remaining;
    logic [7:0]  status, level, rd_mux;
    logic [8:0]  cnt9;
    logic        ack, dma_tc;
    logic [7:0]  data_out_q;
    logic        data_oe_q;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, pop, push_req, fifo_clr;
    logic          push_ok, pop_ok, drop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
            sync_vld <= '0;
        end else begin
            sync_q[0]   <= {bus.address, bus.aen, bus.ior, bus.iow, bus.dack};
            sync_vld[0] <= 1'b1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i]   <= sync_q[i-1];
                sync_vld[i] <= sync_vld[i-1];
            end
        end
    end

    assign {addr_s, aen_s, ior_s, iow_s, dack_s} = sync_q[SYNC_STAGES-1];
    assign sync_ok = sync_vld[SYNC_STAGES-1];

    // A strobe only arms once it has been seen high after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ior_d   <= 1'b1;
            iow_d   <= 1'b1;
            ior_arm <= 1'b0;
            iow_arm <= 1'b0;
        end else begin
            ior_d   <= ior_s;
            iow_d   <= iow_s;
            ior_arm <= ior_arm | (sync_ok & ior_s);
            iow_arm <= iow_arm | (sync_ok & iow_s);
        end
    end

    assign ior_fall = ior_arm & ior_d & ~ior_s;
    assign ior_rise = ~ior_d & ior_s;
    assign iow_fall = iow_arm & iow_d & ~iow_s;
    assign iow_rise = ~iow_d & iow_s;
    assign sel      = !aen_s && (addr_s[15:4] == BASE_ADDR[15:4]);
    assign dma_sel  = aen_s && !dack_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (ior_fall && sel)          state_n = IO_RD;
                else if (iow_fall && sel)     state_n = IO_WR;
                else if (iow_fall && dma_sel) state_n = DMA_WR;
            end
            IO_RD:   if (ior_rise) state_n = IDLE;
            IO_WR:   if (iow_rise) state_n = IDLE;
            DMA_WR:  if (iow_rise) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        rd_start = (state == IDLE) && ior_fall && sel;
        rd_end   = (state == IO_RD) && ior_rise;
        wr_done  = (state == IO_WR) && iow_rise;
        dma_done = (state == DMA_WR) && iow_rise;
        cyc_dma  = (state == DMA_WR);
    end

    assign cnt9   = 9'(count);
    assign level  = cnt9[8] ? 8'hFF : cnt9[7:0];
    assign status = {3'b000, dma_active, overflow, irq_pending, full, empty};
    assign ack    = rd_start && (addr_s[3:0] == 4'h6);
    assign dma_tc = dma_done && dma_active && (remaining == 17'd1);

    always_comb begin
        rd_mux = 8'hFF;
        case (addr_s[3:0])
            4'h0:       rd_mux = {6'b000000, ctrl};
            4'h1, 4'h6: rd_mux = status;
            4'h2:       rd_mux = 8'h00;
            4'h3:       rd_mux = level;
            4'h4:       rd_mux = cnt_lo;
            4'h5:       rd_mux = cnt_hi;
            4'h7:       rd_mux = scratch;
            default:    rd_mux = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            off_q       <= '0;
            ctrl        <= '0;
            cnt_lo      <= '0;
            cnt_hi      <= '0;
            scratch     <= '0;
            dma_active  <= 1'b0;
            remaining   <= '0;
            irq_pending <= 1'b0;
            overflow    <= 1'b0;
            data_oe_q   <= 1'b0;
            data_out_q  <= '0;
        end else begin
            if (state == IDLE) off_q <= addr_s[3:0];
            if (wr_done) begin
                case (off_q)
                    4'h0:    ctrl    <= bus.data_in[1:0];
                    4'h4:    cnt_lo  <= bus.data_in;
                    4'h5:    cnt_hi  <= bus.data_in;
                    4'h7:    scratch <= bus.data_in;
                    default: ;
                endcase
            end
            if (wr_done && off_q == 4'h0 && !bus.data_in[1]) begin
                dma_active <= 1'b0;
            end else if (wr_done && off_q == 4'h5 && ctrl[1]) begin
                remaining  <= 17'({bus.data_in, cnt_lo}) + 17'd1;
                dma_active <= 1'b1;
            end else if (dma_done && dma_active) begin
                remaining <= remaining - 17'd1;
                if (remaining == 17'd1) dma_active <= 1'b0;
            end
            if (local_irq_set()) irq_pending <= 1'b1;
            else if (ack)        irq_pending <= 1'b0;
            if (drop)     overflow <= 1'b1;
            else if (ack) overflow <= 1'b0;
            if (rd_start) begin
                data_oe_q  <= 1'b1;
                data_out_q <= rd_mux;
            end else if (rd_end) begin
                data_oe_q  <= 1'b0;
                data_out_q <= '0;
            end
        end
    end

    function automatic logic local_irq_set();
        return bus.local_irq_req || (dma_tc && ctrl[0]);
    endfunction

    assign pop      = !empty && bus.local_rd_ready;
    assign push_req = (wr_done && off_q == 4'h2) || dma_done;
    assign fifo_clr = wr_done && off_q == 4'h0 && bus.data_in[2];
    assign push_ok  = push_req && (!full || pop) && !fifo_clr;
    assign drop     = push_req && full && !pop && !fifo_clr;
    assign pop_ok   = pop && !fifo_clr;
    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= bus.data_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (fifo_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop_ok)      count <= count + CW'(1);
            else if (pop_ok && !push_ok) count <= count - CW'(1);
        end
    end

    assign bus.data_out       = data_out_q;
    assign bus.data_oe        = data_oe_q;
    assign bus.drq            = dma_active && !full && !cyc_dma;
    assign bus.irq            = irq_pending && ctrl[0];
    assign bus.local_rd_valid = !empty;
    assign bus.local_rd_data  = empty ? 8'h00 : mem[rd_ptr];
endmodule

// File: tb/tb_isa_io_target.sv
// Randomised scoreboard bench for isa_io_target against a
// register-level reference model.
module tb_isa_io_target;
    localparam int          DEPTH = 16;
    localparam logic [15:0] BASE  = 16'h0220;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    isa_io_target_if bus ();

    isa_io_target #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH),
        .SYNC_STAGES(2)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Reference model state
    logic [1:0] m_ctrl;
    logic [7:0] m_cnt_lo, m_cnt_hi, m_scratch;
    bit         m_irq, m_ovf, m_dma;
    int         m_rem;
    logic [7:0] m_fifo[$];
    logic [7:0] rd_exp[$];

    function automatic void m_reset();
        m_ctrl = '0; m_cnt_lo = '0; m_cnt_hi = '0; m_scratch = '0;
        m_irq = 0; m_ovf = 0; m_dma = 0; m_rem = 0;
        m_fifo.delete();
    endfunction

    function automatic logic [7:0] m_status();
        return {3'b000, m_dma, m_ovf, m_irq,
                m_fifo.size() == DEPTH, m_fifo.size() == 0};
    endfunction

    function automatic void m_push(logic [7:0] d);
        if (m_fifo.size() >= DEPTH) m_ovf = 1;
        else m_fifo.push_back(d);
    endfunction

    function automatic void m_write(int off, logic [7:0] d);
        case (off)
            0: begin
                m_ctrl = d[1:0];
                if (d[2]) m_fifo.delete();
                if (!d[1]) m_dma = 0;
            end
            2: m_push(d);
            4: m_cnt_lo = d;
            5: begin
                m_cnt_hi = d;
                if (m_ctrl[1]) begin
                    m_rem = int'({d, m_cnt_lo}) + 1;
                    m_dma = 1;
                end
            end
            7: m_scratch = d;
            default: ;
        endcase
    endfunction

    function automatic logic [7:0] m_read(int off);
        logic [7:0] r;
        case (off)
            0: r = {6'b000000, m_ctrl};
            1: r = m_status();
            2: r = 8'h00;
            3: r = (m_fifo.size() > 255) ? 8'hFF : 8'(m_fifo.size());
            4: r = m_cnt_lo;
            5: r = m_cnt_hi;
            6: begin r = m_status(); m_irq = 0; m_ovf = 0; end
            7: r = m_scratch;
            default: r = 8'hFF;
        endcase
        return r;
    endfunction

    function automatic void m_dma_byte(logic [7:0] d);
        m_push(d);
        if (m_dma) begin
            m_rem--;
            if (m_rem == 0) begin
                m_dma = 0;
                if (m_ctrl[0]) m_irq = 1;
            end
        end
    endfunction

    // Monitor: read responses, FIFO pops and drq pulses
    logic oe_prev = 1'b0;
    logic drq_prev = 1'b0;
    int   oe_rises = 0;
    int   drq_pulses = 0;

    always @(negedge clk) begin
        if (bus.data_oe && !oe_prev) begin
            oe_rises++;
            if (rd_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected act=%0h exp=none", bus.data_out);
            end else begin
                chk("rd_data", 32'(bus.data_out), 32'(rd_exp.pop_front()));
            end
        end
        if (!bus.data_oe && oe_prev)
            chk("rd_idle_zero", 32'(bus.data_out), 32'h0);
        oe_prev = bus.data_oe;
        if (bus.drq && !drq_prev) drq_pulses++;
        drq_prev = bus.drq;
        if (bus.local_rd_valid && bus.local_rd_ready) begin
            if (m_fifo.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected act=%0h exp=none", bus.local_rd_data);
            end else begin
                chk("pop_data", 32'(bus.local_rd_data), 32'(m_fifo.pop_front()));
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic bit in_win(logic [15:0] a);
        return a[15:4] == BASE[15:4];
    endfunction

    task automatic io_write(logic [15:0] a, logic [7:0] d);
        bus.address = a;
        bus.aen = 1'b0;
        bus.data_in = d;
        tick(1);
        bus.iow = 1'b0;
        tick(6);
        if (in_win(a)) m_write(int'(a[3:0]), d);
        bus.iow = 1'b1;
        tick(6);
    endtask

    task automatic io_read(logic [15:0] a);
        int n0;
        bit hit;
        hit = in_win(a);
        bus.address = a;
        bus.aen = 1'b0;
        tick(1);
        n0 = oe_rises;
        if (hit) rd_exp.push_back(m_read(int'(a[3:0])));
        bus.ior = 1'b0;
        tick(6);
        bus.ior = 1'b1;
        tick(5);
        if (hit) begin
            chk("rd_resp", oe_rises - n0, 1);
            if (oe_rises == n0 && rd_exp.size() > 0) void'(rd_exp.pop_back());
        end else begin
            chk("rd_no_resp", oe_rises - n0, 0);
        end
    endtask

    task automatic dma_byte(logic [7:0] d);
        int t;
        t = 0;
        while (!bus.drq && t < 500) begin
            tick(1);
            t++;
        end
        chk("drq_wait", 32'(bus.drq), 32'h1);
        if (!bus.drq) return;
        bus.aen = 1'b1;
        bus.dack = 1'b0;
        bus.data_in = d;
        tick(1);
        bus.iow = 1'b0;
        tick(6);
        m_dma_byte(d);
        bus.iow = 1'b1;
        tick(5);
        bus.dack = 1'b1;
        bus.aen = 1'b0;
        tick(2);
    endtask

    task automatic drain();
        int t;
        t = 0;
        bus.local_rd_ready = 1'b1;
        while (bus.local_rd_valid && t < 400) begin
            tick(1);
            t++;
        end
        bus.local_rd_ready = 1'b0;
        tick(1);
        chk("drain_valid", 32'(bus.local_rd_valid), 32'h0);
        chk("drain_model", m_fifo.size(), 0);
    endtask

    task automatic irq_pulse();
        bus.local_irq_req = 1'b1;
        tick(1);
        bus.local_irq_req = 1'b0;
        m_irq = 1;
        tick(2);
    endtask

    initial begin
        int p0;
        bus.address = '0;
        bus.aen = 1'b1;
        bus.ior = 1'b1;
        bus.iow = 1'b1;
        bus.dack = 1'b1;
        bus.data_in = '0;
        bus.local_rd_ready = 1'b0;
        bus.local_irq_req = 1'b0;
        m_reset();

        tick(3);
        chk("rst_data_oe", 32'(bus.data_oe), 32'h0);
        chk("rst_data_out", 32'(bus.data_out), 32'h0);
        chk("rst_drq", 32'(bus.drq), 32'h0);
        chk("rst_irq", 32'(bus.irq), 32'h0);
        chk("rst_valid", 32'(bus.local_rd_valid), 32'h0);
        chk("rst_rd_data", 32'(bus.local_rd_data), 32'h0);
        reset_n = 1'b1;
        tick(6);

        io_read(16'h0221);
        io_read(16'h0231);
        io_write(16'h0227, 8'hA5);
        io_read(16'h0227);
        io_read(16'h0229);

        for (int i = 0; i < 17; i++) io_write(16'h0222, 8'(i));
        io_read(16'h0223);
        io_read(16'h0221);
        io_read(16'h0226);
        drain();

        p0 = drq_pulses;
        io_write(16'h0220, 8'h03);
        io_write(16'h0224, 8'h03);
        io_write(16'h0225, 8'h00);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chk("irq_before_tc", 32'(bus.irq), 32'h0);
            dma_byte(8'h10 + 8'(i));
        end
        tick(10);
        chk("dma4_pulses", drq_pulses - p0, 4);
        chk("dma4_irq", 32'(bus.irq), 32'h1);
        chk("dma4_drq_idle", 32'(bus.drq), 32'h0);
        io_read(16'h0223);
        io_read(16'h0226);
        chk("irq_cleared", 32'(bus.irq), 32'h0);
        drain();

        p0 = drq_pulses;
        io_write(16'h0224, 8'h13);
        io_write(16'h0225, 8'h00);
        for (int i = 0; i < DEPTH; i++) dma_byte(8'h40 + 8'(i));
        tick(20);
        chk("drq_stall", 32'(bus.drq), 32'h0);
        io_read(16'h0223);
        bus.local_rd_ready = 1'b1;
        for (int i = DEPTH; i < 20; i++) dma_byte(8'h40 + 8'(i));
        tick(10);
        chk("dma20_pulses", drq_pulses - p0, 20);
        chk("dma20_irq", 32'(bus.irq), 32'h1);
        drain();
        io_read(16'h0226);

        for (int i = 0; i < 60; i++) begin
            int op;
            logic [15:0] a;
            logic [7:0] d;
            op = int'($urandom_range(0, 9));
            a = BASE + 16'($urandom_range(0, 15));
            d = 8'($urandom);
            if (op < 4) io_write(a, d);
            else if (op < 8) io_read(a);
            else if (op == 8) begin
                a = 16'($urandom);
                if (in_win(a)) a[15] = ~a[15];
                io_read(a);
            end else irq_pulse();
        end
        chk("rand_irq", 32'(bus.irq), 32'(m_irq && m_ctrl[0]));
        io_read(16'h0221);
        io_read(16'h0223);
        drain();
        io_read(16'h0226);

        io_write(16'h0220, 8'h03);
        io_write(16'h0224, 8'h05);
        io_write(16'h0225, 8'h00);
        irq_pulse();
        chk("pre_rst_drq", 32'(bus.drq), 32'h1);
        chk("pre_rst_irq", 32'(bus.irq), 32'h1);
        bus.address = 16'h0221;
        tick(1);
        rd_exp.push_back(m_read(1));
        bus.ior = 1'b0;
        tick(6);
        chk("pre_rst_oe", 32'(bus.data_oe), 32'h1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_drq", 32'(bus.drq), 32'h0);
        chk("mid_rst_oe", 32'(bus.data_oe), 32'h0);
        chk("mid_rst_irq", 32'(bus.irq), 32'h0);
        chk("mid_rst_dout", 32'(bus.data_out), 32'h0);
        m_reset();
        tick(3);
        reset_n = 1'b1;
        tick(20);
        chk("held_strobe_ignored", 32'(bus.data_oe), 32'h0);
        bus.ior = 1'b1;
        tick(5);
        io_read(16'h0221);

        tick(5);
        chk("rd_pending", rd_exp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
